// File: rtl/read_stream_check.sv
`default_nettype none
// ============================================================================
// Module      : read_stream_check
// Description : AXI4 read-back checker for the DDR4 stream test. Issues INCR
//               read bursts of up to 256 x 512-bit beats and compares every
//               beat against the stream pattern {stream, iter, cnt + lane}.
//               Counts mismatching beats, captures the first failing beat
//               address and lane map, and flags RRESP/RID/RLAST errors.
// Ports       : clk, reset (sync, active-high)
//               en, err_clr, addr, iter_num, stream_num, burst_length
//               done, adr_neg, err_cnt, err_flag, first_err_addr, err_lanes,
//               resp_err, id_err, len_err
//               AXI4 AR channel (master) and R channel (master side)
// Revision    : 1.0 - initial release
// ============================================================================
module read_stream_check (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         err_clr,
  input  logic [31:0]  addr,
  input  logic [7:0]   iter_num,
  input  logic [7:0]   stream_num,
  input  logic [7:0]   burst_length,
  output logic         done,
  output logic         adr_neg,
  output logic [31:0]  err_cnt,
  output logic         err_flag,
  output logic [31:0]  first_err_addr,
  output logic [15:0]  err_lanes,
  output logic         resp_err,
  output logic         id_err,
  output logic         len_err,
  input  logic         ARREADY,
  output logic [31:0]  ARADDR,
  output logic [3:0]   ARID,
  output logic [7:0]   ARLEN,
  output logic [2:0]   ARSIZE,
  output logic [1:0]   ARBURST,
  output logic [1:0]   ARLOCK,
  output logic [3:0]   ARCACHE,
  output logic [2:0]   ARPROT,
  output logic         ARVALID,
  input  logic [3:0]   RID,
  input  logic [511:0] RDATA,
  input  logic [1:0]   RRESP,
  input  logic         RLAST,
  input  logic         RVALID,
  output logic         RREADY
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t       state;
  logic [3:0]   arid_r;
  logic [7:0]   len_r;
  logic [31:0]  base_r;
  logic [7:0]   beat_cnt;
  logic [15:0]  exp_cnt;

  // compare pipeline stage 1
  logic         s1_valid;
  logic [15:0]  s1_mis;
  logic [31:0]  s1_addr;

  logic         beat_acc;
  logic [15:0]  lane_mis;
  logic [31:0]  beat_addr;
  logic [7:0]   last_idx;

  // fixed burst attributes: 64-byte beats, INCR, normal access
  assign ARSIZE  = 3'b110;
  assign ARBURST = 2'b01;
  assign ARLOCK  = 2'b00;
  assign ARCACHE = 4'b0000;
  assign ARPROT  = 3'b000;

  // burst_length 0 wraps to ARLEN 0xFF, i.e. 256 beats
  assign ARLEN   = burst_length - 8'd1;
  assign ARADDR  = addr;
  assign ARID    = arid_r;

  assign ARVALID = (state == S_ADDR);
  assign RREADY  = (state == S_DATA);
  assign adr_neg = ARVALID && ARREADY;

  assign beat_acc  = RVALID && RREADY;
  assign done      = beat_acc && RLAST;
  assign beat_addr = base_r + 32'({beat_cnt, 6'd0});
  assign last_idx  = len_r - 8'd1;

  // lane k expects {stream, iter, exp_cnt + k}, lane sum wraps at 16 bits
  always_comb begin
    lane_mis = '0;
    for (int k = 0; k < 16; k++) begin
      lane_mis[k] = (RDATA[32*k +: 32] !=
                     {stream_num, iter_num, 16'(exp_cnt + 16'(k))});
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      arid_r         <= '0;
      len_r          <= '0;
      base_r         <= '0;
      beat_cnt       <= '0;
      exp_cnt        <= '0;
      s1_valid       <= 1'b0;
      s1_mis         <= '0;
      s1_addr        <= '0;
      err_cnt        <= '0;
      err_flag       <= 1'b0;
      first_err_addr <= '0;
      err_lanes      <= '0;
      resp_err       <= 1'b0;
      id_err         <= 1'b0;
      len_err        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (en) state <= S_ADDR;
        end
        S_ADDR: begin
          if (ARREADY) begin
            state    <= S_DATA;
            len_r    <= burst_length;
            base_r   <= addr;
            beat_cnt <= '0;
          end
        end
        S_DATA: begin
          if (beat_acc) beat_cnt <= beat_cnt + 8'd1;
          // RLAST always ends the burst, early or not
          if (beat_acc && RLAST) begin
            arid_r <= arid_r + 4'd1;
            state  <= en ? S_ADDR : S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

      // pattern counter runs across bursts; only an idle, disabled checker
      // restarts it so a fresh run lines up with a fresh generator run
      if ((state == S_IDLE) && !en)
        exp_cnt <= '0;
      else if (beat_acc)
        exp_cnt <= exp_cnt + 16'h0010;

      // a beat accepted together with err_clr is dropped with the clear
      s1_valid <= beat_acc && !err_clr;
      s1_mis   <= lane_mis;
      s1_addr  <= beat_addr;

      if (err_clr) begin
        err_cnt        <= '0;
        err_flag       <= 1'b0;
        first_err_addr <= '0;
        err_lanes      <= '0;
        resp_err       <= 1'b0;
        id_err         <= 1'b0;
        len_err        <= 1'b0;
      end else begin
        if (s1_valid && (s1_mis != 16'd0)) begin
          if (err_cnt != 32'hFFFF_FFFF) err_cnt <= err_cnt + 32'd1;
          if (!err_flag) begin
            err_flag       <= 1'b1;
            first_err_addr <= s1_addr;
            err_lanes      <= s1_mis;
          end
        end
        if (beat_acc && (RRESP != 2'b00)) resp_err <= 1'b1;
        if (beat_acc && (RID != arid_r))  id_err   <= 1'b1;
        // early RLAST or missing RLAST on the expected final beat
        if (beat_acc && RLAST && (beat_cnt != last_idx))   len_err <= 1'b1;
        if (beat_acc && !RLAST && (beat_cnt == last_idx))  len_err <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_read_stream_check.sv
`default_nettype none
// ============================================================================
// Module      : tb_read_stream_check
// Description : Directed self-checking bench for read_stream_check. Acts as
//               the AXI4 slave, returns pattern data (optionally corrupted)
//               and checks counters, first-error capture and protocol flags.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_read_stream_check;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic         err_clr;
  logic [31:0]  addr;
  logic [7:0]   iter_num;
  logic [7:0]   stream_num;
  logic [7:0]   burst_length;
  logic         done;
  logic         adr_neg;
  logic [31:0]  err_cnt;
  logic         err_flag;
  logic [31:0]  first_err_addr;
  logic [15:0]  err_lanes;
  logic         resp_err;
  logic         id_err;
  logic         len_err;
  logic         ARREADY;
  logic [31:0]  ARADDR;
  logic [3:0]   ARID;
  logic [7:0]   ARLEN;
  logic [2:0]   ARSIZE;
  logic [1:0]   ARBURST;
  logic [1:0]   ARLOCK;
  logic [3:0]   ARCACHE;
  logic [2:0]   ARPROT;
  logic         ARVALID;
  logic [3:0]   RID;
  logic [511:0] RDATA;
  logic [1:0]   RRESP;
  logic         RLAST;
  logic         RVALID;
  logic         RREADY;

  int total = 0;
  int bad   = 0;

  // bench-side model of the pattern counter and the expected read ID
  logic [15:0] m_exp  = '0;
  logic [3:0]  m_arid = '0;

  read_stream_check dut (
    .clk(clk), .reset(reset), .en(en), .err_clr(err_clr), .addr(addr),
    .iter_num(iter_num), .stream_num(stream_num), .burst_length(burst_length),
    .done(done), .adr_neg(adr_neg), .err_cnt(err_cnt), .err_flag(err_flag),
    .first_err_addr(first_err_addr), .err_lanes(err_lanes),
    .resp_err(resp_err), .id_err(id_err), .len_err(len_err),
    .ARREADY(ARREADY), .ARADDR(ARADDR), .ARID(ARID), .ARLEN(ARLEN),
    .ARSIZE(ARSIZE), .ARBURST(ARBURST), .ARLOCK(ARLOCK), .ARCACHE(ARCACHE),
    .ARPROT(ARPROT), .ARVALID(ARVALID), .RID(RID), .RDATA(RDATA),
    .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] pat(input logic [15:0] e);
    logic [511:0] p;
    p = '0;
    for (int k = 0; k < 16; k++)
      p[32*k +: 32] = {stream_num, iter_num, 16'(e + 16'(k))};
    return p;
  endfunction

  // wait (bounded) for ARVALID, check the request, then complete the handshake
  task automatic do_ar(input logic [7:0] exp_len, input logic [31:0] exp_addr);
    int n;
    n = 0;
    while (ARVALID !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("arvalid_wait", ARVALID, 1);
    chk("arlen", ARLEN, exp_len);
    chk("araddr", ARADDR, exp_addr);
    chk("arid", ARID, m_arid);
    ARREADY = 1'b1;
    #1;
    chk("adr_neg", adr_neg, 1);
    @(posedge clk); #1;
    ARREADY = 1'b0;
    chk("rready_rise", RREADY, 1);
  endtask

  // one R beat; bit 0 of every lane set in flip is inverted
  task automatic beat(input logic [15:0] flip, input logic [3:0] id,
                      input logic [1:0] resp, input logic last);
    logic [511:0] d;
    d = pat(m_exp);
    for (int k = 0; k < 16; k++)
      if (flip[k]) d[32*k] = ~d[32*k];
    RDATA  = d;
    RID    = id;
    RRESP  = resp;
    RLAST  = last;
    RVALID = 1'b1;
    #1;
    chk("done", done, last);
    @(posedge clk); #1;
    RVALID = 1'b0;
    RLAST  = 1'b0;
    RRESP  = 2'b00;
    m_exp  = m_exp + 16'h0010;
    if (last) m_arid = m_arid + 4'd1;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; err_clr = 1'b0; addr = 32'h1000;
    iter_num = 8'h34; stream_num = 8'h12; burst_length = 8'd4;
    ARREADY = 1'b0; RID = '0; RDATA = '0; RRESP = '0; RLAST = 1'b0; RVALID = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // reset state
    chk("rst_arvalid", ARVALID, 0);
    chk("rst_rready", RREADY, 0);
    chk("rst_done", done, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_err_flag", err_flag, 0);
    chk("rst_first_addr", first_err_addr, 0);
    chk("rst_err_lanes", err_lanes, 0);
    chk("rst_flags", {resp_err, id_err, len_err}, 0);
    chk("rst_arid", ARID, 0);
    chk("const_ar", {ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT}, {3'b110, 2'b01, 2'b00, 4'b0, 3'b0});
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_arvalid", ARVALID, 0);

    // burst 1: clean 4-beat burst, ARVALID one cycle after en
    en = 1'b1;
    #1;
    chk("arvalid_pre", ARVALID, 0);
    @(posedge clk); #1;
    chk("arvalid_rise", ARVALID, 1);
    do_ar(8'd3, 32'h1000);
    for (int i = 0; i < 4; i++) beat(16'h0, m_arid, 2'b00, i == 3);
    chk("b2b_arvalid", ARVALID, 1);
    chk("b1_rready_low", RREADY, 0);
    @(posedge clk); #1;
    chk("b1_err_cnt", err_cnt, 0);
    chk("b1_err_flag", err_flag, 0);

    // burst 2: exp_cnt continues at 0x40; beat 2 lane 5 and beat 3 lane 0 bad
    do_ar(8'd3, 32'h1000);
    beat(16'h0000, m_arid, 2'b00, 1'b0);
    beat(16'h0000, m_arid, 2'b00, 1'b0);
    beat(16'h0020, m_arid, 2'b00, 1'b0);
    chk("b2_lat1_err_cnt", err_cnt, 0);
    beat(16'h0001, m_arid, 2'b00, 1'b1);
    chk("b2_lat2_err_cnt", err_cnt, 1);
    chk("b2_err_flag", err_flag, 1);
    chk("b2_err_lanes", err_lanes, 16'h0020);
    chk("b2_first_addr", first_err_addr, 32'h1080);
    @(posedge clk); #1;
    chk("b2_err_cnt2", err_cnt, 2);
    chk("b2_first_addr_hold", first_err_addr, 32'h1080);
    chk("b2_err_lanes_hold", err_lanes, 16'h0020);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    chk("clr_err_cnt", err_cnt, 0);
    chk("clr_err_flag", err_flag, 0);
    chk("clr_first_addr", first_err_addr, 0);
    chk("clr_err_lanes", err_lanes, 0);

    // burst 3: RRESP error with good data, then wrong RID
    do_ar(8'd3, 32'h1000);
    beat(16'h0, m_arid, 2'b00, 1'b0);
    beat(16'h0, m_arid, 2'b10, 1'b0);
    chk("b3_resp_err", resp_err, 1);
    chk("b3_id_err_pre", id_err, 0);
    beat(16'h0, m_arid + 4'd1, 2'b00, 1'b0);
    chk("b3_id_err", id_err, 1);
    beat(16'h0, m_arid, 2'b00, 1'b1);
    @(posedge clk); #1;
    chk("b3_err_cnt", err_cnt, 0);
    chk("b3_len_err", len_err, 0);

    // burst 4: early RLAST on beat 1
    do_ar(8'd3, 32'h1000);
    beat(16'h0, m_arid, 2'b00, 1'b0);
    beat(16'h0, m_arid, 2'b00, 1'b1);
    chk("b4_len_err_early", len_err, 1);
    chk("b4_next_ar", ARVALID, 1);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    chk("b4_clr_flags", {resp_err, id_err, len_err}, 0);

    // burst 5: RLAST missing on beat 3, extra beat 4 carries RLAST; en drops
    do_ar(8'd3, 32'h1000);
    for (int i = 0; i < 3; i++) beat(16'h0, m_arid, 2'b00, 1'b0);
    chk("b5_len_err_pre", len_err, 0);
    beat(16'h0, m_arid, 2'b00, 1'b0);
    chk("b5_len_err_missing", len_err, 1);
    chk("b5_rready_hold", RREADY, 1);
    en = 1'b0;
    beat(16'h0, m_arid, 2'b00, 1'b1);
    chk("b5_idle_arvalid", ARVALID, 0);
    chk("b5_idle_rready", RREADY, 0);
    chk("b5_err_cnt", err_cnt, 0);
    @(posedge clk); #1;
    m_exp = 16'h0;
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;

    // 16 full 256-beat bursts: exp_cnt wraps back to 0x0000
    burst_length = 8'd0;
    addr = 32'h0;
    en = 1'b1;
    for (int b = 0; b < 16; b++) begin
      do_ar(8'hFF, 32'h0);
      if (b == 15) burst_length = 8'd4;
      for (int i = 0; i < 256; i++) beat(16'h0, m_arid, 2'b00, i == 255);
    end
    chk("wrap_model_exp", m_exp, 16'h0);
    @(posedge clk); #1;
    chk("long_err_cnt", err_cnt, 0);
    chk("long_len_err", len_err, 0);
    chk("long_id_err", id_err, 0);

    // burst after wrap, en dropped mid-burst: burst completes, then idle
    do_ar(8'd3, 32'h0);
    beat(16'h0, m_arid, 2'b00, 1'b0);
    beat(16'h0, m_arid, 2'b00, 1'b0);
    en = 1'b0;
    beat(16'h0, m_arid, 2'b00, 1'b0);
    chk("drop_rready_hold", RREADY, 1);
    beat(16'h0, m_arid, 2'b00, 1'b1);
    chk("drop_idle_arvalid", ARVALID, 0);
    chk("drop_idle_rready", RREADY, 0);
    @(posedge clk); #1;
    chk("wrap_err_cnt", err_cnt, 0);
    m_exp = 16'h0;

    // restart: pattern restarts at 0; beat 1 lane 3 bad with wrong RID
    addr = 32'h2000;
    en = 1'b1;
    do_ar(8'd3, 32'h2000);
    beat(16'h0000, m_arid, 2'b00, 1'b0);
    beat(16'h0008, m_arid + 4'd1, 2'b00, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("restart_err_cnt", err_cnt, 1);
    chk("restart_err_lanes", err_lanes, 16'h0008);
    chk("restart_first_addr", first_err_addr, 32'h2040);
    chk("restart_id_err", id_err, 1);

    // reset mid-burst
    reset = 1'b1;
    en = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_rready", RREADY, 0);
    chk("mid_rst_arvalid", ARVALID, 0);
    chk("mid_rst_err_cnt", err_cnt, 0);
    chk("mid_rst_err_flag", err_flag, 0);
    chk("mid_rst_first_addr", first_err_addr, 0);
    chk("mid_rst_err_lanes", err_lanes, 0);
    chk("mid_rst_flags", {resp_err, id_err, len_err}, 0);
    chk("mid_rst_arid", ARID, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
